fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of the asynchronous FIFO among NUM_REQ frame-oriented requesters. It runs in the FIFO write clock domain and drives the FIFO's write increment and write data directly. Each granted requester holds the port until its frame-end beat is written, so frames are never interleaved. It stalls on FIFO full and recovers from a requester that stops mid-frame through an idle timeout.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the frame requesters, the FIFO flags and the write-port arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ*DATA_WIDTH-1:0] data;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;
  logic                          busy;
  logic                          abort;

  modport master (
    output req, last, data, wfull,
    input  winc, wdata, grant, ack, busy, abort
  );

  modport slave (
    input  req, last, data, wfull,
    output winc, wdata, grant, ack, busy, abort
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, frame-locking arbiter for the write port of the async FIFO.
// A granted requester owns the port until its frame-end beat is written or it
// stays idle long enough to trip the timeout. Runs in the FIFO write clock domain.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TO_CYCLES  = 15
) (
  input  logic             CLK,
  input  logic             RST,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TcW  = $clog2(TO_CYCLES + 1);

  localparam logic [IdxW-1:0] PtrRst = IdxW'(NUM_REQ - 1);
  localparam logic [TcW-1:0]  TcLast = TcW'(TO_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     g_q, g_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [TcW-1:0]      tcnt_q, tcnt_d;
  logic                abort_q, abort_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic                  locked;
  logic                  req_g;
  logic                  last_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  winc;
  logic [NUM_REQ-1:0]    owner_oh;

  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  pick_valid;
  int unsigned           pick_sel;
  logic [IdxW-1:0]       pick_idx;

  // Owner's view of the requester bus and the combinational write path.
  always_comb begin
    locked   = (state_q == StLocked);
    req_g    = bus.req[g_q];
    last_g   = bus.last[g_q];
    data_g   = bus.data[g_q*DATA_WIDTH +: DATA_WIDTH];
    owner_oh = NUM_REQ'(1) << g_q;
    winc     = locked & req_g & ~bus.wfull;
  end

  // Round-robin pick: rotate req so bit 0 is requester ptr+1, take the lowest set bit.
  // ptr_q+1 wrapping at the IdxW boundary is harmless since the index is reduced mod NUM_REQ.
  always_comb begin
    req_dbl    = {bus.req, bus.req};
    req_rot    = NUM_REQ'(req_dbl >> (ptr_q + 1'b1));
    pick_valid = 1'b0;
    pick_sel   = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!pick_valid && req_rot[j]) begin
        pick_valid = 1'b1;
        pick_sel   = (32'(ptr_q) + 1 + j) % NUM_REQ;
      end
    end
    pick_idx = IdxW'(pick_sel);
  end

  // Next-state logic: acquire in IDLE, release on frame end or idle timeout.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StLocked;
          g_d     = pick_idx;
          tcnt_d  = '0;
        end
      end
      StLocked: begin
        if (winc && last_g) begin
          state_d = StIdle;
          ptr_d   = g_q;
          tcnt_d  = '0;
        end else if (req_g) begin
          // A full-FIFO stall with req held is not idleness.
          tcnt_d = '0;
        end else if (tcnt_q == TcLast) begin
          state_d = StIdle;
          ptr_d   = g_q;
          tcnt_d  = '0;
          abort_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    grant_d = (state_d == StLocked) ? (NUM_REQ'(1) << g_d) : '0;
  end

  // State and registered outputs; RST wins over any in-flight frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      g_q     <= '0;
      ptr_q   <= PtrRst;
      tcnt_q  <= '0;
      abort_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      abort_q <= abort_d;
      grant_q <= grant_d;
    end
  end

  // Drive the bus: write path combinational, ownership and abort registered.
  always_comb begin
    bus.winc  = winc;
    bus.wdata = locked ? data_g : '0;
    bus.ack   = winc ? owner_oh : '0;
    bus.grant = grant_q;
    bus.busy  = |grant_q;
    bus.abort = abort_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a frame-level reference model.
module tb_fifo_wr_arbiter;
  localparam int DW   = 8;
  localparam int NR   = 4;
  localparam int TO   = 15;
  localparam int NCYC = 4000;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [NR-1:0] ack;
    logic          busy;
    logic          abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TO_CYCLES(TO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;
  int n_frame = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] wr_q[$];

  // Reference model: owner = -1 when the port is free.
  int m_owner = -1;
  int m_prev  = NR - 1;
  int m_idle  = 0;
  bit m_abort = 1'b0;

  int sil[NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int  o;
    bit  wr;
    if (rst) begin
      m_owner = -1;
      m_prev  = NR - 1;
      m_idle  = 0;
      m_abort = 1'b0;
      return;
    end
    m_abort = 1'b0;
    o = m_owner;
    if (o < 0) begin
      for (int k = 1; k <= NR; k++) begin
        if (bus.req[(m_prev + k) % NR]) begin
          m_owner = (m_prev + k) % NR;
          m_idle  = 0;
          break;
        end
      end
    end else begin
      wr = bus.req[o] && !bus.wfull;
      if (wr && bus.last[o]) begin
        m_owner = -1;
        m_prev  = o;
        n_frame++;
      end else if (bus.req[o]) begin
        m_idle = 0;
      end else if (m_idle == TO - 1) begin
        m_owner = -1;
        m_prev  = o;
        m_abort = 1'b1;
        m_idle  = 0;
        n_abort++;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e = '0;
    if (m_owner >= 0) begin
      e.grant = NR'(1) << m_owner;
      e.busy  = 1'b1;
      e.wdata = bus.data[m_owner*DW +: DW];
      e.winc  = bus.req[m_owner] && !bus.wfull;
      e.ack   = e.winc ? e.grant : '0;
    end
    e.abort = m_abort;
    exp_q.push_back(e);
    if (e.winc) wr_q.push_back(e.wdata);
  endtask

  task automatic drive(input int cyc);
    if (cyc < 1) begin
      rst     = 1'b1;
      bus.req = '1;
    end else begin
      rst = ($urandom % 400) == 0;
      for (int i = 0; i < NR; i++) begin
        if (sil[i] > 0) begin
          bus.req[i] = 1'b0;
          sil[i]--;
        end else begin
          bus.req[i] = ($urandom % 4) != 0;
          if (($urandom % 25) == 0) sil[i] = $urandom_range(30, 12);
        end
      end
    end
    for (int i = 0; i < NR; i++) bus.last[i] = ($urandom % 4) == 0;
    bus.data  = NR*DW'($urandom);
    bus.wfull = ($urandom % 5) == 0;
  endtask

  // Stimulus: step the model on each edge, then present new inputs and queue expectations.
  initial begin
    for (int i = 0; i < NR; i++) sil[i] = 0;
    bus.req   = '1;
    bus.last  = '0;
    bus.data  = '0;
    bus.wfull = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      drive(cyc);
      push_expect();
    end
    @(negedge clk);
    @(negedge clk);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: compare DUT outputs mid-cycle; pop a FIFO write whenever winc is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(bus.grant), 32'(e.grant));
        chk("busy",  32'(bus.busy),  32'(e.busy));
        chk("abort", 32'(bus.abort), 32'(e.abort));
        chk("winc",  32'(bus.winc),  32'(e.winc));
        chk("ack",   32'(bus.ack),   32'(e.ack));
        chk("wdata", 32'(bus.wdata), 32'(e.wdata));
        chk("winc_vs_wfull", 32'(bus.winc & bus.wfull), 32'd0);
      end
      if (bus.winc === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("fifo_write_expected", 32'd1, 32'd0);
        end else begin
          chk("fifo_write_data", 32'(bus.wdata), 32'(wr_q.pop_front()));
        end
      end
    end
  end

endmodule
